// File: rtl/spi_reg_master_bridge_if.sv
// Register bus between the SPI bridge (master) and the per-domain reg lists (slave).
// Strobes are levels; addr/wr_data stay stable while a strobe is high.
interface spi_reg_master_bridge_if #(
    parameter int SPI_ADDR_LENGTH = 16,
    parameter int SHORT_REG_WD    = 16,
    parameter int RD_SLAVE_NUM    = 3
);
    logic                                 wr_en;
    logic                                 rd_en;
    logic                                 cmd_is_rd;
    logic [SPI_ADDR_LENGTH-1:0]           addr;
    logic [SHORT_REG_WD-1:0]              wr_data;
    logic [RD_SLAVE_NUM-1:0]              rd_sel;
    logic [RD_SLAVE_NUM*SHORT_REG_WD-1:0] rd_data;

    modport master (
        output wr_en, rd_en, cmd_is_rd, addr, wr_data,
        input  rd_sel, rd_data
    );

    modport slave (
        input  wr_en, rd_en, cmd_is_rd, addr, wr_data,
        output rd_sel, rd_data
    );
endinterface

// File: rtl/spi_reg_master_bridge.sv
// Oversampled mode-0 SPI slave that turns host frames (cmd, addr, data)
// into level register-bus strobes and returns the selected read word on MISO.
module spi_reg_master_bridge #(
    parameter int                SPI_ADDR_LENGTH = 16,
    parameter int                SHORT_REG_WD    = 16,
    parameter int                CMD_WD          = 8,
    parameter logic [CMD_WD-1:0] CMD_WR          = 8'h80,
    parameter logic [CMD_WD-1:0] CMD_RD          = 8'h3d,
    parameter int                RD_SLAVE_NUM    = 3,
    parameter int                RD_LATCH_DLY    = 2
) (
    input  logic clk_ctrl,
    input  logic reset_ctrl,
    input  logic i_spi_clk,
    input  logic i_spi_cs_n,
    input  logic i_spi_mosi,
    output logic o_spi_miso,
    output logic o_spi_miso_oe,
    output logic o_frame_err,
    spi_reg_master_bridge_if.master bus
);
    localparam int AD_WD  = (SPI_ADDR_LENGTH > SHORT_REG_WD) ? SPI_ADDR_LENGTH : SHORT_REG_WD;
    localparam int SR_WD  = (AD_WD > CMD_WD) ? AD_WD : CMD_WD;
    localparam int CNT_WD = $clog2(SR_WD + 1);
    localparam logic [CNT_WD-1:0] CMD_LAST  = CNT_WD'(CMD_WD - 1);
    localparam logic [CNT_WD-1:0] ADDR_LAST = CNT_WD'(SPI_ADDR_LENGTH - 1);
    localparam logic [CNT_WD-1:0] DATA_LAST = CNT_WD'(SHORT_REG_WD - 1);
    localparam logic [2:0]        DLY_LAST  = 3'(RD_LATCH_DLY - 1);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WR_DATA, WR_HOLD, RD_WAIT, RD_DATA, DONE
    } state_t;

    state_t                   state, state_nx;
    logic                     err_nx;
    logic [2:0]               sck_s, cs_s, mosi_s;
    logic                     sck_rise, sck_fall, cs_rise, cs_fall;
    logic [1:0]               fill;
    logic                     armed;
    logic [CNT_WD-1:0]        cnt;
    logic [SR_WD-2:0]         sr;
    logic [SR_WD-1:0]         fw;
    logic [CMD_WD-1:0]        cmd_q;
    logic [2:0]               dly;
    logic [SHORT_REG_WD-1:0]  rd_sr, rd_word;
    logic                     wr_en, rd_en, cmd_is_rd;
    logic [SPI_ADDR_LENGTH-1:0] addr;
    logic [SHORT_REG_WD-1:0]  wr_data;

    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign sck_fall = ~sck_s[1] & sck_s[2];
    assign cs_rise  = cs_s[1] & ~cs_s[2];
    assign cs_fall  = ~cs_s[1] & cs_s[2];
    assign fw       = {sr, mosi_s[2]};

    assign bus.wr_en     = wr_en;
    assign bus.rd_en     = rd_en;
    assign bus.cmd_is_rd = cmd_is_rd;
    assign bus.addr      = addr;
    assign bus.wr_data   = wr_data;

    // Lowest index wins: scan downwards so it is written last.
    always_comb begin
        rd_word = '0;
        for (int k = RD_SLAVE_NUM - 1; k >= 0; k--)
            if (bus.rd_sel[k]) rd_word = bus.rd_data[k*SHORT_REG_WD +: SHORT_REG_WD];
    end

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        unique case (state)
            IDLE:    if (cs_fall && armed) state_nx = CMD;
            CMD:     if (cs_rise) begin state_nx = IDLE; err_nx = 1'b1; end
                     else if (sck_rise && cnt == CMD_LAST) state_nx = ADDR;
            ADDR:    if (cs_rise) begin state_nx = IDLE; err_nx = 1'b1; end
                     else if (sck_rise && cnt == ADDR_LAST) begin
                         if (cmd_q == CMD_WR)      state_nx = WR_DATA;
                         else if (cmd_q == CMD_RD) state_nx = RD_WAIT;
                         else begin state_nx = DONE; err_nx = 1'b1; end
                     end
            WR_DATA: if (cs_rise) begin state_nx = IDLE; err_nx = 1'b1; end
                     else if (sck_rise && cnt == DATA_LAST) state_nx = WR_HOLD;
            WR_HOLD: if (cs_rise) state_nx = IDLE;
            RD_WAIT: if (cs_rise) begin state_nx = IDLE; err_nx = 1'b1; end
                     else if (dly == DLY_LAST) state_nx = RD_DATA;
            RD_DATA: if (cs_rise) begin state_nx = IDLE; err_nx = 1'b1; end
                     else if (sck_rise && cnt == DATA_LAST) state_nx = DONE;
            DONE:    if (cs_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // armed blocks a frame that was already under way when reset released.
    always_ff @(posedge clk_ctrl) begin
        if (reset_ctrl) begin
            sck_s  <= 3'b000;
            cs_s   <= 3'b111;
            mosi_s <= 3'b000;
            fill   <= 2'd0;
            armed  <= 1'b0;
        end else begin
            sck_s  <= {sck_s[1:0], i_spi_clk};
            cs_s   <= {cs_s[1:0], i_spi_cs_n};
            mosi_s <= {mosi_s[1:0], i_spi_mosi};
            if (fill != 2'd3) fill <= fill + 2'd1;
            if (fill == 2'd3 && cs_s[2]) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk_ctrl) begin
        if (reset_ctrl) begin
            state         <= IDLE;
            o_frame_err   <= 1'b0;
            cnt           <= '0;
            sr            <= '0;
            cmd_q         <= '0;
            dly           <= '0;
            rd_sr         <= '0;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
            cmd_is_rd     <= 1'b0;
            addr          <= '0;
            wr_data       <= '0;
            o_spi_miso    <= 1'b0;
            o_spi_miso_oe <= 1'b0;
        end else begin
            state       <= state_nx;
            o_frame_err <= err_nx;
            if (sck_rise) begin
                sr  <= fw[SR_WD-2:0];
                cnt <= cnt + 1'b1;
            end
            if (state != state_nx) cnt <= '0;
            unique case (state)
                CMD: if (state_nx == ADDR) begin
                    cmd_q     <= fw[CMD_WD-1:0];
                    cmd_is_rd <= (fw[CMD_WD-1:0] == CMD_RD);
                end
                ADDR: if (state_nx != ADDR && state_nx != IDLE) begin
                    addr <= fw[SPI_ADDR_LENGTH-1:0];
                    dly  <= '0;
                    if (state_nx == RD_WAIT) rd_en <= 1'b1;
                end
                WR_DATA: if (state_nx == WR_HOLD) begin
                    wr_data <= fw[SHORT_REG_WD-1:0];
                    wr_en   <= 1'b1;
                end
                RD_WAIT: begin
                    dly <= dly + 3'd1;
                    if (state_nx == RD_DATA) begin
                        rd_sr         <= rd_word;
                        o_spi_miso    <= rd_word[SHORT_REG_WD-1];
                        o_spi_miso_oe <= 1'b1;
                    end
                end
                // The fall after the last address bit precedes the data phase.
                RD_DATA: if (sck_fall && cnt != '0) begin
                    rd_sr      <= rd_sr << 1;
                    o_spi_miso <= rd_sr[SHORT_REG_WD-2];
                end
                default: ;
            endcase
            if (cs_rise) begin
                wr_en         <= 1'b0;
                rd_en         <= 1'b0;
                cmd_is_rd     <= 1'b0;
                o_spi_miso    <= 1'b0;
                o_spi_miso_oe <= 1'b0;
            end
        end
    end
endmodule
